// File: rtl/bank_fifo_pkg.sv
// Shared defaults and bank-index wrap helper for the banked FIFO.
package bank_fifo_pkg;
    localparam int DEF_W = 16;
    localparam int DEF_D = 128;
    localparam int DEF_N = 2;

    // Bank count need not be a power of two, so wrap is explicit.
    function automatic int unsigned bank_inc(input int unsigned b, input int unsigned n);
        return (b == n - 1) ? 0 : b + 1;
    endfunction
endpackage

// File: rtl/bank_fifo_multi_ptr.sv
// Bank/word pointer pair: word steps on inc, bank advances (word to 0) on adv.
module bank_fifo_multi_ptr
    import bank_fifo_pkg::*;
#(
    parameter int D = DEF_D,
    parameter int N = DEF_N
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inc,
    input  logic                      adv,
    input  logic [$clog2(D+1)-1:0]    lim,
    output logic [$clog2(N)-1:0]      bank,
    output logic [$clog2(D)-1:0]      word,
    output logic                      last
);
    localparam int BANK_IDX_W = $clog2(N);
    localparam int LEN_W      = $clog2(D+1);

    assign last = (LEN_W'(word) == lim - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= '0;
            word <= '0;
        end else if (adv) begin
            bank <= BANK_IDX_W'(bank_inc(32'(bank), N));
            word <= '0;
        end else if (inc) begin
            word <= word + 1'b1;
        end
    end
endmodule

// File: rtl/bank_fifo_multi.sv
// N-bank FIFO with whole-bank handoff; writer commits on full or flush.
// Optional BANK_FIFO_MULTI_STATS_EN adds saturating stall counters.
module bank_fifo_multi
    import bank_fifo_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int D = DEF_D,
    parameter int N = DEF_N
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_trigger,
    input  logic [W-1:0]              w_data,
    input  logic                      w_flush,
    output logic                      w_ready,
    output logic                      w_done,
    input  logic                      r_trigger,
    output logic                      r_ready,
    output logic                      r_done,
    output logic [W-1:0]              r_data,
    output logic                      r_last,
    output logic [$clog2(N+1)-1:0]    level
`ifdef BANK_FIFO_MULTI_STATS_EN
    ,
    output logic [15:0]               w_stall_cnt,
    output logic [15:0]               r_stall_cnt
`endif
);
    localparam int BANK_IDX_W = $clog2(N);
    localparam int WORD_IDX_W = $clog2(D);
    localparam int LEVEL_W    = $clog2(N+1);
    localparam int LEN_W      = $clog2(D+1);

    logic [W-1:0]            mem [N*D];
    logic [LEN_W-1:0]        len [N];
    logic [BANK_IDX_W-1:0]   wb, rb;
    logic [WORD_IDX_W-1:0]   wi, ri;
    logic                    w_last, r_last_raw;
    logic                    flush_go, w_commit, r_release;

    assign w_ready   = (level != LEVEL_W'(N));
    assign w_done    = w_trigger & w_ready;
    // A flush commits only if the bank ends up non-empty (same-cycle word counts).
    assign flush_go  = w_flush & w_ready & ((wi != '0) | w_trigger);
    assign w_commit  = (w_done & w_last) | flush_go;

    assign r_ready   = (level != '0);
    assign r_done    = r_trigger & r_ready;
    assign r_last    = r_ready & r_last_raw;
    assign r_release = r_done & r_last_raw;
    assign r_data    = mem[{rb, ri}];

    bank_fifo_multi_ptr #(.D(D), .N(N)) u_wptr (
        .clk(clk), .rst_n(rst_n), .inc(w_done), .adv(w_commit),
        .lim(LEN_W'(D)), .bank(wb), .word(wi), .last(w_last)
    );

    bank_fifo_multi_ptr #(.D(D), .N(N)) u_rptr (
        .clk(clk), .rst_n(rst_n), .inc(r_done), .adv(r_release),
        .lim(len[rb]), .bank(rb), .word(ri), .last(r_last_raw)
    );

    always_ff @(posedge clk) begin
        if (w_done)
            mem[{wb, wi}] <= w_data;
        if (w_commit)
            len[wb] <= LEN_W'(wi) + LEN_W'(w_done);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            level <= '0;
        else
            level <= level + LEVEL_W'(w_commit) - LEVEL_W'(r_release);
    end

`ifdef BANK_FIFO_MULTI_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_stall_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_trigger && !w_ready && w_stall_cnt != 16'hFFFF)
                w_stall_cnt <= w_stall_cnt + 16'd1;
            if (r_trigger && !r_ready && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bank_fifo_multi.sv
// Scoreboard bench for bank_fifo_multi (N=4, D=8, W=16) against a queue-based bank model.
module tb_bank_fifo_multi;
    localparam int W = 16;
    localparam int D = 8;
    localparam int N = 4;

    logic clk = 0, rst_n = 0;
    logic w_trigger = 0, w_flush = 0, r_trigger = 0;
    logic [W-1:0] w_data = '0;
    logic w_ready, w_done, r_ready, r_done, r_last;
    logic [W-1:0] r_data;
    logic [$clog2(N+1)-1:0] level;
`ifdef BANK_FIFO_MULTI_STATS_EN
    logic [15:0] w_stall_cnt, r_stall_cnt;
`endif

    bank_fifo_multi #(.W(W), .D(D), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .w_trigger(w_trigger), .w_data(w_data),
        .w_flush(w_flush), .w_ready(w_ready), .w_done(w_done),
        .r_trigger(r_trigger), .r_ready(r_ready), .r_done(r_done),
        .r_data(r_data), .r_last(r_last), .level(level)
`ifdef BANK_FIFO_MULTI_STATS_EN
        , .w_stall_cnt(w_stall_cnt), .r_stall_cnt(r_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] d; logic l; } item_t;
    item_t       exp_q[$];
    logic [W-1:0] cur_q[$];
    int mlevel = 0, nwr = 0, n_pass = 0, n_chk = 0, both_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model and monitor: bank contents as queues, level as an integer.
    always @(negedge clk) begin
        if (rst_n) begin
            bit acc, fl, rd, com, rel;
            acc = w_trigger && mlevel < N;
            fl  = w_flush && mlevel < N;
            rd  = r_trigger && mlevel > 0;
            chk("w_ready", int'(w_ready), int'(mlevel < N));
            chk("r_ready", int'(r_ready), int'(mlevel > 0));
            chk("level", int'(level), mlevel);
            chk("w_done", int'(w_done), int'(acc));
            chk("r_done", int'(r_done), int'(rd));
            if (mlevel > 0) begin
                chk("r_data", int'(r_data), int'(exp_q[0].d));
                chk("r_last", int'(r_last), int'(exp_q[0].l));
            end else begin
                chk("r_last_idle", int'(r_last), 0);
            end
            rel = 0;
            com = 0;
            if (rd) begin
                rel = exp_q[0].l;
                void'(exp_q.pop_front());
            end
            if (acc) begin
                cur_q.push_back(w_data);
                nwr++;
            end
            if (cur_q.size() == D || (fl && cur_q.size() > 0)) begin
                foreach (cur_q[i]) exp_q.push_back('{cur_q[i], i == cur_q.size() - 1});
                cur_q.delete();
                com = 1;
            end
            if (com && rel) both_seen++;
            mlevel = mlevel + int'(com) - int'(rel);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        w_trigger = 0; w_flush = 0; r_trigger = 0;
        repeat (n) step();
    endtask

    task automatic write_seq(input int n, input int base);
        w_flush = 0;
        for (int i = 0; i < n; i++) begin
            w_trigger = 1;
            w_data = W'(base + i);
            step();
        end
        w_trigger = 0;
    endtask

    task automatic drain();
        int t;
        w_trigger = 0; w_flush = 0; r_trigger = 1;
        t = 0;
        while (mlevel > 0 && t < 200) begin step(); t++; end
        chk("drain_timeout", int'(t < 200), 1);
        r_trigger = 0;
        step();
    endtask

    initial begin
        int t, target;
        r_trigger = 1;
        #3;
        chk("rst_r_ready", int'(r_ready), 0);
        chk("rst_r_done", int'(r_done), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_w_ready", int'(w_ready), 1);
        chk("rst_r_last", int'(r_last), 0);
        @(posedge clk); #1;
        r_trigger = 0;
        step();
        rst_n = 1;
        step();
`ifdef BANK_FIFO_MULTI_STATS_EN
        r_trigger = 1;
        repeat (5) step();
        r_trigger = 0;
        step();
        chk("r_stall_cnt", int'(r_stall_cnt), 5);
        chk("w_stall_cnt", int'(w_stall_cnt), 0);
`endif
        // One full bank, then read it back.
        write_seq(8, 0);
        chk("full_bank_level", int'(level), 1);
        drain();

        // Fill all banks; the 33rd word must stall until a bank is read.
        write_seq(32, 16'h100);
        chk("all_full_level", int'(level), 4);
        chk("all_full_w_ready", int'(w_ready), 0);
        w_trigger = 1; w_data = 16'h1ff;
        repeat (3) step();
        r_trigger = 1;
        step();
        w_trigger = 0;
        drain();

        // Partial bank via flush, then a full bank.
        write_seq(3, 16'h200);
        w_flush = 1; step(); w_flush = 0;
        step();
        chk("flush_level", int'(level), 1);
        write_seq(8, 16'h300);
        drain();

        // Write+flush in one cycle after 4 words, then a flush at wi==0.
        write_seq(4, 16'h400);
        w_trigger = 1; w_flush = 1; w_data = 16'h404; step();
        w_trigger = 0; step();
        chk("wf_level", int'(level), 1);
        w_flush = 1; step(); w_flush = 0;
        step();
        chk("empty_flush_level", int'(level), 1);
        drain();

        // Lockstep streaming: commit and release coincide.
        w_trigger = 1; r_trigger = 1;
        for (int i = 0; i < 200; i++) begin
            w_data = W'($urandom);
            step();
        end
        chk("commit_release_overlap", int'(both_seen > 0), 1);

        // Randomized streaming with occasional flushes, 1000 words.
        target = nwr + 1000;
        t = 0;
        while (nwr < target && t < 20000) begin
            w_trigger = ($urandom_range(0, 3) != 0);
            r_trigger = ($urandom_range(0, 3) != 0);
            w_flush   = ($urandom_range(0, 15) == 0);
            w_data    = W'($urandom);
            step();
            t++;
        end
        chk("stream_timeout", int'(t < 20000), 1);
        w_trigger = 0; w_flush = 1; step(); w_flush = 0;
        drain();
        chk("final_level", int'(level), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
